// File: rtl/wb_bus_initiator.sv
// Single-transfer Wishbone classic initiator with a bounded wait for the slave ack.
// Build option WB_INIT_READ_MASK_EN zeroes unselected byte lanes of captured read data.
module wb_bus_initiator #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        req_read_i,
    input  logic        req_write_i,
    input  logic [31:0] req_adr_i,
    input  logic [31:0] req_dat_i,
    input  logic [3:0]  req_sel_i,
    output logic        req_busy_o,
    output logic        req_done_o,
    output logic        req_err_o,
    output logic [31:0] req_dat_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_stb_o,
    output logic        wbm_cyc_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i
);

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX  = '1;

    typedef enum logic {ST_IDLE, ST_BUS} state_t;

    state_t      r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic        r_cyc, w_cyc_nxt;
    logic        r_we, w_we_nxt;
    logic [31:0] r_adr, w_adr_nxt;
    logic [31:0] r_wdat, w_wdat_nxt;
    logic [3:0]  r_sel, w_sel_nxt;
    logic        r_done, w_done_nxt;
    logic        r_err, w_err_nxt;
    logic [31:0] r_rdat, w_rdat_nxt;
    logic        w_req;
    logic        w_timeout;
    logic [31:0] w_rd_capture;

    assign w_req = req_write_i | req_read_i;
    // The abort fires on the edge that would bring the count up to TIMEOUT_CYCLES.
    assign w_timeout = (TIMEOUT_CYCLES != 0) && !wbm_ack_i && (r_cnt == CNT_LAST);

`ifdef WB_INIT_READ_MASK_EN
    assign w_rd_capture = wbm_dat_i & {{8{r_sel[3]}}, {8{r_sel[2]}}, {8{r_sel[1]}}, {8{r_sel[0]}}};
`else
    assign w_rd_capture = wbm_dat_i;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_cyc   <= 1'b0;
            r_we    <= 1'b0;
            r_adr   <= '0;
            r_wdat  <= '0;
            r_sel   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_rdat  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cyc   <= w_cyc_nxt;
            r_we    <= w_we_nxt;
            r_adr   <= w_adr_nxt;
            r_wdat  <= w_wdat_nxt;
            r_sel   <= w_sel_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_rdat  <= w_rdat_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_req) w_state_nxt = ST_BUS;
            ST_BUS:  if (wbm_ack_i || w_timeout) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_cyc_nxt  = r_cyc;
        w_we_nxt   = r_we;
        w_adr_nxt  = r_adr;
        w_wdat_nxt = r_wdat;
        w_sel_nxt  = r_sel;
        w_done_nxt = 1'b0;
        w_err_nxt  = 1'b0;
        w_rdat_nxt = r_rdat;
        case (r_state)
            ST_IDLE: begin
                // Write has priority when both requests arrive together.
                if (w_req) begin
                    w_cyc_nxt  = 1'b1;
                    w_we_nxt   = req_write_i;
                    w_adr_nxt  = req_adr_i & 32'hFFFF_FFFC;
                    w_wdat_nxt = req_write_i ? req_dat_i : 32'h0;
                    w_sel_nxt  = req_sel_i;
                    w_cnt_nxt  = '0;
                end
            end
            ST_BUS: begin
                if (wbm_ack_i) begin
                    w_cyc_nxt  = 1'b0;
                    w_we_nxt   = 1'b0;
                    w_done_nxt = 1'b1;
                    if (!r_we) w_rdat_nxt = w_rd_capture;
                end else begin
                    if (r_cnt != CNT_MAX) w_cnt_nxt = r_cnt + 1'b1;
                    if (w_timeout) begin
                        w_cyc_nxt  = 1'b0;
                        w_we_nxt   = 1'b0;
                        w_done_nxt = 1'b1;
                        w_err_nxt  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign req_busy_o = (r_state == ST_BUS);
    assign req_done_o = r_done;
    assign req_err_o  = r_err;
    assign req_dat_o  = r_rdat;
    assign wbm_adr_o  = r_adr;
    assign wbm_dat_o  = r_wdat;
    assign wbm_sel_o  = r_sel;
    assign wbm_we_o   = r_we;
    assign wbm_stb_o  = r_cyc;
    assign wbm_cyc_o  = r_cyc;

endmodule

// File: tb/tb_wb_bus_initiator.sv
// Scoreboard bench for wb_bus_initiator: expected bus cycles and completions are queued
// by the stimulus and checked by an independent monitor on the falling clock edge.
module tb_wb_bus_initiator;

    logic        wb_clk_i;
    logic        wb_rst_i;
    logic        req_read_i, req_write_i;
    logic [31:0] req_adr_i, req_dat_i;
    logic [3:0]  req_sel_i;
    logic        req_busy_o, req_done_o, req_err_o;
    logic [31:0] req_dat_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_stb_o, wbm_cyc_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;

    wb_bus_initiator #(.TIMEOUT_CYCLES(4)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .req_read_i(req_read_i), .req_write_i(req_write_i),
        .req_adr_i(req_adr_i), .req_dat_i(req_dat_i), .req_sel_i(req_sel_i),
        .req_busy_o(req_busy_o), .req_done_o(req_done_o), .req_err_o(req_err_o),
        .req_dat_o(req_dat_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_we_o(wbm_we_o), .wbm_stb_o(wbm_stb_o), .wbm_cyc_o(wbm_cyc_o),
        .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
    );

    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        int          gap;
    } cyc_exp_t;

    typedef struct {
        logic        err;
        logic [31:0] rdat;
        int          len;
    } done_exp_t;

    cyc_exp_t  exp_cyc_q[$];
    done_exp_t exp_done_q[$];
    int checks = 0;
    int errors = 0;

`ifdef WB_INIT_READ_MASK_EN
    localparam logic [31:0] MASK_RD_EXP = 32'h0000_CCDD;
`else
    localparam logic [31:0] MASK_RD_EXP = 32'hAABB_CCDD;
`endif

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push_cyc(input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, input logic we, input int gap);
        cyc_exp_t e;
        e.adr = adr; e.dat = dat; e.sel = sel; e.we = we; e.gap = gap;
        exp_cyc_q.push_back(e);
    endtask

    task automatic push_done(input logic err, input logic [31:0] rdat, input int len);
        done_exp_t e;
        e.err = err; e.rdat = rdat; e.len = len;
        exp_done_q.push_back(e);
    endtask

    // Called on a falling edge; the request is sampled on the next rising edge.
    task automatic do_req(input logic w, input logic r, input logic [31:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel);
        req_write_i = w; req_read_i = r;
        req_adr_i = adr; req_dat_i = dat; req_sel_i = sel;
        @(negedge wb_clk_i);
        req_write_i = 1'b0; req_read_i = 1'b0;
    endtask

    // Slave acks in the k-th BUS cycle counted from the current falling edge.
    task automatic ack_after(input int k, input logic [31:0] d);
        repeat (k - 1) @(negedge wb_clk_i);
        wbm_ack_i = 1'b1; wbm_dat_i = d;
        @(negedge wb_clk_i);
        wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
    endtask

    // Monitor
    initial begin
        logic prev_cyc;
        logic busy_ok;
        int len;
        int low_len;
        cyc_exp_t  ec;
        done_exp_t ed;
        prev_cyc = 1'b0; busy_ok = 1'b1; len = 0; low_len = 0;
        forever begin
            @(negedge wb_clk_i);
            if (wbm_cyc_o) begin
                if (!prev_cyc) begin
                    if (exp_cyc_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_cyc actual adr=%h required no cycle", wbm_adr_o);
                    end else begin
                        ec = exp_cyc_q.pop_front();
                        chk("cyc_adr", wbm_adr_o, ec.adr);
                        chk("cyc_dat", wbm_dat_o, ec.dat);
                        chk("cyc_sel", 32'(wbm_sel_o), 32'(ec.sel));
                        chk("cyc_we", 32'(wbm_we_o), 32'(ec.we));
                        chk("cyc_stb", 32'(wbm_stb_o), 32'd1);
                        if (ec.gap != 0) chk("cyc_gap", 32'(low_len), 32'(ec.gap));
                    end
                    len = 1;
                    busy_ok = req_busy_o;
                end else begin
                    len++;
                    busy_ok = busy_ok & req_busy_o;
                end
                low_len = 0;
            end else begin
                low_len++;
            end
            if (req_done_o) begin
                if (exp_done_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done actual err=%0d required no done", req_err_o);
                end else begin
                    ed = exp_done_q.pop_front();
                    chk("done_err", 32'(req_err_o), 32'(ed.err));
                    chk("done_rdat", req_dat_o, ed.rdat);
                    chk("done_cyc_len", 32'(len), 32'(ed.len));
                    chk("done_busy_during_bus", 32'(busy_ok), 32'd1);
                    chk("done_cyc_low", 32'(wbm_cyc_o), 32'd0);
                end
            end else if (req_err_o) begin
                checks++; errors++;
                $display("FAIL err_without_done actual=1 required=0");
            end
            prev_cyc = wbm_cyc_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Stimulus
    initial begin
        wb_rst_i = 1'b1;
        req_read_i = 1'b0; req_write_i = 1'b0;
        req_adr_i = 32'h0; req_dat_i = 32'h0; req_sel_i = 4'h0;
        wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
        repeat (3) @(negedge wb_clk_i);
        chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("rst_stb", 32'(wbm_stb_o), 32'd0);
        chk("rst_busy", 32'(req_busy_o), 32'd0);
        chk("rst_done", 32'(req_done_o), 32'd0);
        chk("rst_rdat", req_dat_o, 32'h0);
        chk("rst_adr", wbm_adr_o, 32'h0);
        wb_rst_i = 1'b0;
        repeat (2) @(negedge wb_clk_i);

        // write, ack in first BUS cycle
        push_cyc(32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 1'b1, 0);
        push_done(1'b0, 32'h0, 1);
        do_req(1'b1, 1'b0, 32'h3000_0006, 32'hDEAD_BEEF, 4'hF);
        ack_after(1, 32'h5555_5555);
        repeat (2) @(negedge wb_clk_i);

        // read, ack in third BUS cycle
        push_cyc(32'h3000_0010, 32'h0, 4'hF, 1'b0, 0);
        push_done(1'b0, 32'h1234_5678, 3);
        do_req(1'b0, 1'b1, 32'h3000_0010, 32'h9999_9999, 4'hF);
        ack_after(3, 32'h1234_5678);
        repeat (2) @(negedge wb_clk_i);

        // slave never acks: abort after 4 cycles, read data kept
        push_cyc(32'h0000_0100, 32'h0, 4'hF, 1'b0, 0);
        push_done(1'b1, 32'h1234_5678, 4);
        do_req(1'b0, 1'b1, 32'h0000_0103, 32'h0, 4'hF);
        repeat (6) @(negedge wb_clk_i);

        // both requests: write wins; pulse while busy ignored; request on done cycle
        push_cyc(32'h0000_0200, 32'hCAFE_F00D, 4'h5, 1'b1, 0);
        push_done(1'b0, 32'h1234_5678, 2);
        do_req(1'b1, 1'b1, 32'h0000_0201, 32'hCAFE_F00D, 4'h5);
        req_read_i = 1'b1;
        @(negedge wb_clk_i);
        req_read_i = 1'b0;
        ack_after(1, 32'h7777_7777);
        chk("b2b_done_now", 32'(req_done_o), 32'd1);
        push_cyc(32'h0000_0204, 32'h0000_0011, 4'hF, 1'b1, 1);
        push_done(1'b0, 32'h1234_5678, 1);
        do_req(1'b1, 1'b0, 32'h0000_0204, 32'h0000_0011, 4'hF);
        ack_after(1, 32'h0);
        repeat (2) @(negedge wb_clk_i);

        // reset in the middle of a BUS cycle, then a late ack
        push_cyc(32'h0000_0300, 32'h0, 4'hF, 1'b0, 0);
        do_req(1'b0, 1'b1, 32'h0000_0300, 32'h0, 4'hF);
        #2 wb_rst_i = 1'b1;
        #1;
        chk("midrst_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("midrst_stb", 32'(wbm_stb_o), 32'd0);
        chk("midrst_busy", 32'(req_busy_o), 32'd0);
        chk("midrst_done", 32'(req_done_o), 32'd0);
        repeat (2) @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        wbm_ack_i = 1'b1; wbm_dat_i = 32'h0BAD_0BAD;
        @(negedge wb_clk_i);
        wbm_ack_i = 1'b0; wbm_dat_i = 32'h0;
        chk("late_ack_rdat", req_dat_o, 32'h0);
        chk("late_ack_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("late_ack_busy", 32'(req_busy_o), 32'd0);
        repeat (2) @(negedge wb_clk_i);

        // partial byte-lane read
        push_cyc(32'h0000_0400, 32'h0, 4'h3, 1'b0, 0);
        push_done(1'b0, MASK_RD_EXP, 1);
        do_req(1'b0, 1'b1, 32'h0000_0400, 32'h0, 4'h3);
        ack_after(1, 32'hAABB_CCDD);
        repeat (3) @(negedge wb_clk_i);

        chk("cyc_queue_drained", 32'(exp_cyc_q.size()), 32'd0);
        chk("done_queue_drained", 32'(exp_done_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_bus_initiator.md
Name: wb_bus_initiator

Overview:
- Wishbone classic single-transfer manager (initiator). It turns a simple request/strobe interface from a team core into one Wishbone read or write cycle.
- Sits in front of a wishbone_arbitrator manager slot, on the opposite side of the peripherals (SRAM, GPIO/LA control, team slaves).
- Provides a bounded-wait timeout so that a missing slave ack cannot hang the requesting core.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles with cyc/stb asserted and no ack before the cycle is aborted; 0 disables the timeout.

Ports:
- wb_clk_i  input  1  bus clock
- wb_rst_i  input  1  asynchronous reset, active-high
- req_read_i  input  1  start read request (sampled in IDLE only)
- req_write_i  input  1  start write request (sampled in IDLE only)
- req_adr_i  input  32  byte address
- req_dat_i  input  32  write data
- req_sel_i  input  4  byte lane select
- req_busy_o  output  1  transaction in flight
- req_done_o  output  1  one-cycle pulse: transaction finished (ack or timeout)
- req_err_o  output  1  one-cycle pulse with req_done_o when terminated by timeout
- req_dat_o  output  32  read data, held until the next read completes
- wbm_adr_o  output  32  Wishbone address, word aligned
- wbm_dat_o  output  32  Wishbone write data
- wbm_sel_o  output  4  Wishbone byte select
- wbm_we_o  output  1  Wishbone write enable
- wbm_stb_o  output  1  Wishbone strobe
- wbm_cyc_o  output  1  Wishbone cycle
- wbm_ack_i  input  1  Wishbone acknowledge
- wbm_dat_i  input  32  Wishbone read data

Behaviour:
- One clock (wb_clk_i); reset is asynchronous, active-high (wb_rst_i). All outputs are registered.
- Reset values: every output is 0, req_dat_o = 0, state = IDLE, timeout counter = 0.
- FSM states:
  - IDLE: on a clock edge with req_write_i or req_read_i high, latch address/data/sel and go to BUS.
    - If both are high in the same cycle, the write is taken and the read is dropped.
    - wbm_adr_o = {req_adr_i[31:2], 2'b00}.
    - wbm_we_o = 1 for a write, 0 for a read.
    - wbm_dat_o = req_dat_i for a write, 0 for a read.
    - wbm_sel_o = req_sel_i in both cases.
  - BUS: cyc = stb = 1. Address, data, sel and we are held stable for the whole cycle.
    - Timeout counter increments every BUS cycle without an ack.
    - On the edge where wbm_ack_i = 1: cyc/stb/we fall, req_done_o pulses for exactly 1 cycle, and the FSM returns to IDLE.
    - On a read, wbm_dat_i is captured into req_dat_o on that same edge. On a write, req_dat_o is unchanged.
    - On the edge where the counter reaches TIMEOUT_CYCLES with no ack: cyc/stb fall, req_done_o and req_err_o pulse together, req_dat_o is unchanged, and the FSM returns to IDLE.
- Latency:
  - The request edge is followed by cyc/stb high on the next cycle.
  - With an ack in the first BUS cycle, the total is 2 edges from request to req_done_o.
  - Minimum one cyc-low cycle between back-to-back transactions. A new request is accepted in the same cycle req_done_o is high, and cyc rises on the following edge.
- req_busy_o = 1 exactly while in BUS. Requests while busy are ignored, not queued.
- Ack and timeout on the same edge: ack wins, req_err_o stays 0.
- wbm_ack_i in IDLE is ignored, with no pulse and no state change.
- Timeout counter width is clog2(TIMEOUT_CYCLES+1). It clears on entry to BUS and does not wrap.
- Reset mid-transaction: cyc/stb drop immediately (asynchronously), no done or err pulse, FSM returns to IDLE.

Optional Feature:
- Macro WB_INIT_READ_MASK_EN.
- Defined: on read completion, the bytes of req_dat_o whose wbm_sel_o bit is 0 are written as 0x00.
- Undefined: all 32 bits of wbm_dat_i are captured unmodified, regardless of sel.

Test Plan:
- Write, ack on first BUS cycle: req_write_i=1, adr=0x3000_0006, dat=0xDEAD_BEEF, sel=0xF.
  - Required: next cycle cyc=stb=we=1, wbm_adr_o=0x3000_0004, wbm_dat_o=0xDEADBEEF.
  - Ack 1 cycle later gives req_done_o=1 for 1 cycle, req_err_o=0, cyc=0.
- Read with 3-cycle ack delay: adr=0x3000_0010, slave drives 0x1234_5678.
  - Required: cyc high for 3 cycles, we=0, req_dat_o=0x12345678 on the done cycle, busy=1 throughout BUS.
- Timeout: TIMEOUT_CYCLES=4 with the slave never acking.
  - Required: cyc high for exactly 4 cycles, then req_done_o=req_err_o=1 for 1 cycle, and req_dat_o keeps its previous value.
- Simultaneous requests and busy drop: req_read_i=req_write_i=1.
  - Required: a write cycle is issued.
  - A further request pulsed while busy produces no second cycle.
  - A request asserted on the done cycle starts a new cycle after one cyc-low cycle.
- Reset mid-BUS: assert wb_rst_i with cyc=1.
  - Required: cyc/stb/busy=0 immediately, with no done pulse.
  - A late ack in the cycle after reset is released is ignored.
- With WB_INIT_READ_MASK_EN: read with sel=0x3, slave data 0xAABB_CCDD.
  - Required: req_dat_o=0x0000_CCDD.
  - Without the macro: req_dat_o=0xAABB_CCDD.
